port_uart_tx: RTL

Memory-mapped serial transmitter on the external side of the `dmem_io` I/O ports. The CPU writes a byte to Port 0 and raises a request bit on Port 1. This block captures the byte, acknowledges it back through Port 1 input, and shifts it out as 8N1 UART on `TX`. It runs on the free-running 50 MHz clock, so it has its own synchronizer for the request from the CPU's stepped-clock domain.

---
 rtl/port_uart_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/port_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | port_uart_tx : 8N1 UART transmitter fed from dmem_io Port 0/1 handshake.    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       CLK50M,
  input  logic       reset_n,
  input  logic [7:0] Port0Out,
  input  logic [7:0] Port1Out,
  output logic [7:0] Port1In,
  output logic       TX,
  output logic [7:0] TxCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [15:0] c_last_tick = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  logic [15:0] r_timer;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_s1;
  logic        r_s2;
  logic        r_prev;
  logic        r_ack;
  logic        r_busy;
  logic        r_tx;
  logic [7:0]  r_count;

  logic w_rise;
  logic w_fall;
  logic w_bit_done;
  logic w_unused_port1;

  assign w_rise         = r_s2 & ~r_prev;
  assign w_fall         = ~r_s2 & r_prev;
  assign w_bit_done     = (r_timer == c_last_tick);
  assign w_unused_port1 = &{1'b0, Port1Out[7:1]};

  always_ff @(posedge CLK50M) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_prev  <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
      r_count <= '0;
    end else begin
      r_s1   <= Port1Out[0];
      r_s2   <= r_s1;
      r_prev <= r_s2;

      // ACK follows the request level, independent of frame progress
      if (w_fall) begin
        r_ack <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_rise && !r_busy) begin
            r_shift <= Port0Out;
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_START;
            r_timer <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_timer <= '0;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              // Present the next bit now so TX stays purely registered
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_idx   <= r_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_timer <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= r_count + 8'd1;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Port1In = {6'b000000, r_busy, r_ack};
  assign TX      = r_tx;
  assign TxCount = r_count;

endmodule
`default_nettype wire
